// File: rtl/uart_rx.sv
// UART receive engine: 16x-oversampled, LSB-first, 1 start / DBIT data / stop.
// Define UART_RX_PARITY_EN to add an even-parity bit between data and stop.
module uart_rx #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  input  logic       s_tick,
  output logic       rx_done_tick,
  output logic [7:0] dout,
  output logic       frame_err,
  output logic       parity_err
);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  localparam logic [5:0]  SB_LAST = 6'(SB_TICK - 1);
  localparam logic [2:0]  N_LAST  = 3'(DBIT - 1);
  localparam int unsigned SHIFT   = 8 - DBIT;

  state_t     state_reg, state_next;
  logic [5:0] s_reg, s_next;
  logic [2:0] n_reg, n_next;
  logic [7:0] b_reg, b_next;
  logic [7:0] dout_next;
  logic       ferr_next;
  logic       done_next;
  logic       rx_meta, rx_s;
  logic [7:0] frame_data;

  // Data bits land in the top of b_reg; shift them down to LSB alignment.
  assign frame_data = b_reg >> SHIFT;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

`ifdef UART_RX_PARITY_EN
  logic par_reg, par_next;
  logic perr_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      par_reg    <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      par_reg    <= par_next;
      parity_err <= perr_next;
    end
  end
`else
  assign parity_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      s_reg        <= '0;
      n_reg        <= '0;
      b_reg        <= '0;
      dout         <= '0;
      frame_err    <= 1'b0;
      rx_done_tick <= 1'b0;
    end else begin
      state_reg    <= state_next;
      s_reg        <= s_next;
      n_reg        <= n_next;
      b_reg        <= b_next;
      dout         <= dout_next;
      frame_err    <= ferr_next;
      rx_done_tick <= done_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    s_next     = s_reg;
    n_next     = n_reg;
    b_next     = b_reg;
    dout_next  = dout;
    ferr_next  = frame_err;
    done_next  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_next   = par_reg;
    perr_next  = parity_err;
`endif
    case (state_reg)
      IDLE: begin
        if (!rx_s) begin
          state_next = START;
          s_next     = '0;
        end
      end
      START: begin
        if (s_tick) begin
          if (s_reg == 6'd7) begin
            s_next = '0;
            if (!rx_s) begin
              state_next = DATA;
              n_next     = '0;
            end else begin
              state_next = IDLE;
            end
          end else begin
            s_next = s_reg + 6'd1;
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (s_reg == 6'd15) begin
            s_next = '0;
            b_next = {rx_s, b_reg[7:1]};
            if (n_reg == N_LAST) begin
`ifdef UART_RX_PARITY_EN
              state_next = PARITY;
`else
              state_next = STOP;
`endif
            end else begin
              n_next = n_reg + 3'd1;
            end
          end else begin
            s_next = s_reg + 6'd1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (s_tick) begin
          if (s_reg == 6'd15) begin
            s_next     = '0;
            par_next   = (^frame_data) ^ rx_s;
            state_next = STOP;
          end else begin
            s_next = s_reg + 6'd1;
          end
        end
      end
`endif
      STOP: begin
        if (s_tick) begin
          if (s_reg == SB_LAST) begin
            dout_next  = frame_data;
            ferr_next  = ~rx_s;
            done_next  = 1'b1;
`ifdef UART_RX_PARITY_EN
            perr_next  = par_reg;
`endif
            state_next = IDLE;
          end else begin
            s_next = s_reg + 6'd1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule
